// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the multiplier issue controller.
//   - default operand width, multiplier latency and done-counter width
//   - issue FSM state encoding
//   - product type at the default operand width
package mul_pkg;

   localparam int MUL_WIDTH   = 5;
   localparam int MUL_LATENCY = 7;
   localparam int MUL_CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } mul_state_t;

   typedef logic [2*MUL_WIDTH-1:0] mul_prod_t;

endpackage

// File: rtl/mul_lat_timer.sv
// mul_lat_timer: loadable down-counter that times out the multiplier latency.
//   clk   : clock, posedge
//   reset : synchronous active-high reset, clears the count
//   start : load the count with LATENCY
//   zero  : count has reached zero
module mul_lat_timer
   import mul_pkg::*;
#(
   parameter int LATENCY = MUL_LATENCY
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic zero
);

   // Keep at least one bit so a zero latency still elaborates.
   localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

   logic [CW-1:0] cnt_r;

   // Load on start, otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r <= {CW{1'b0}};
      end else if (start) begin
         cnt_r <= CW'(LATENCY);
      end else if (cnt_r != {CW{1'b0}}) begin
         cnt_r <= cnt_r - CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: sequences one operation at a time through the shift-add
// multiplier. Accepts an operand pair, pulses load, waits out the multiplier
// latency, captures the product and hands it off over a valid/ready port.
//   clk, reset           : clock and synchronous active-high reset
//   in_valid/in_ready    : operand handshake, in_a/in_b operands
//   op_a/op_b/load       : drive the multiplier
//   mul_out              : multiplier product
//   res_valid/res_ready  : result handshake, res_data captured product
//   done_cnt             : number of products handed off (wraps)
// Optional: define MUL_ISSUE_CHECK_EN to add chk_err, a sticky flag set when
// the captured product differs from op_a*op_b.
module mul_issue_ctrl
   import mul_pkg::*;
#(
   parameter int WIDTH   = MUL_WIDTH,
   parameter int LATENCY = MUL_LATENCY,
   parameter int CNT_W   = MUL_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic [WIDTH-1:0]   op_a,
   output logic [WIDTH-1:0]   op_b,
   output logic               load,
   input  logic [2*WIDTH-1:0] mul_out,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [2*WIDTH-1:0] res_data,
`ifdef MUL_ISSUE_CHECK_EN
   output logic               chk_err,
`endif
   output logic [CNT_W-1:0]   done_cnt
);

   mul_state_t state_r;
   logic       timer_start_s;
   logic       timer_zero_s;

`ifdef MUL_ISSUE_CHECK_EN
   logic [2*WIDTH-1:0] exp_prod_s;
   assign exp_prod_s = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);
`endif

   // The multiplier samples load on the edge that leaves LOAD; the timer is
   // armed on that same edge so the capture lands LATENCY+1 edges later.
   assign timer_start_s = (state_r == LOAD);
   assign in_ready      = (state_r == IDLE);

   mul_lat_timer #(.LATENCY(LATENCY)) u_timer (
      .clk   (clk),
      .reset (reset),
      .start (timer_start_s),
      .zero  (timer_zero_s)
   );

   // Issue FSM with registered multiplier and result outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= IDLE;
         op_a      <= {WIDTH{1'b0}};
         op_b      <= {WIDTH{1'b0}};
         load      <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= {(2*WIDTH){1'b0}};
         done_cnt  <= {CNT_W{1'b0}};
`ifdef MUL_ISSUE_CHECK_EN
         chk_err   <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  op_a    <= in_a;
                  op_b    <= in_b;
                  load    <= 1'b1;
                  state_r <= LOAD;
               end else begin
                  state_r <= IDLE;
               end
            end
            LOAD: begin
               load    <= 1'b0;
               state_r <= WAIT;
            end
            WAIT: begin
               if (timer_zero_s) begin
                  res_data  <= mul_out;
                  res_valid <= 1'b1;
                  state_r   <= DONE;
`ifdef MUL_ISSUE_CHECK_EN
                  if (mul_out != exp_prod_s) begin
                     chk_err <= 1'b1;
                  end else begin
                     chk_err <= chk_err;
                  end
`endif
               end else begin
                  state_r <= WAIT;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  done_cnt  <= done_cnt + CNT_W'(1);
                  state_r   <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               load      <= 1'b0;
               res_valid <= 1'b0;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: drives mul_issue_ctrl together with a behavioural
// fixed-latency multiplier and compares every cycle against a reference
// model that tracks the age of the operation in flight.
module tb_mul_issue_ctrl;
   localparam int W   = 5;
   localparam int LAT = 7;
   localparam int CW  = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    in_a = '0;
   logic [W-1:0]    in_b = '0;
   logic [W-1:0]    op_a;
   logic [W-1:0]    op_b;
   logic            load;
   logic [2*W-1:0]  mul_out;
   logic            res_valid;
   logic            res_ready = 1'b0;
   logic [2*W-1:0]  res_data;
   logic [CW-1:0]   done_cnt;
`ifdef MUL_ISSUE_CHECK_EN
   logic            chk_err;
`endif

   mul_issue_ctrl #(.WIDTH(W), .LATENCY(LAT), .CNT_W(CW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .op_a      (op_a),
      .op_b      (op_b),
      .load      (load),
      .mul_out   (mul_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
`ifdef MUL_ISSUE_CHECK_EN
      .chk_err   (chk_err),
`endif
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   // Behavioural multiplier: product is stable LAT cycles after load is
   // sampled; before that it shows the bitwise inverse so an early capture
   // is visible. corrupt forces a wrong product.
   int             m_cnt = 0;
   logic [2*W-1:0] m_prod = '0;
   logic           corrupt = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         m_cnt  <= 0;
         m_prod <= '0;
      end else if (load) begin
         m_cnt  <= LAT;
         m_prod <= (2*W)'(op_a) * (2*W)'(op_b);
      end else if (m_cnt != 0) begin
         m_cnt  <= m_cnt - 1;
      end
   end

   assign mul_out = corrupt ? (m_prod ^ 10'd1) : ((m_cnt == 0) ? m_prod : ~m_prod);

   // Reference model: age = cycles since the accept edge, -1 when idle.
   int             age = -1;
   logic [W-1:0]   e_opa = '0;
   logic [W-1:0]   e_opb = '0;
   logic [2*W-1:0] e_data = '0;
   logic [CW-1:0]  e_done = '0;
   logic           e_chk = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int acc_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
      end
   endtask

   // Check the current cycle, apply inputs for the next edge, advance model.
   task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic rr, input logic rst);
      logic [2*W-1:0] prod;
      check("in_ready",  in_ready,  (age < 0));
      check("load",      load,      (age == 1));
      check("res_valid", res_valid, (age >= LAT + 3));
      check("res_data",  res_data,  e_data);
      check("done_cnt",  done_cnt,  e_done);
      check("op_a",      op_a,      e_opa);
      check("op_b",      op_b,      e_opb);
`ifdef MUL_ISSUE_CHECK_EN
      check("chk_err",   chk_err,   e_chk);
`endif
      if (!rst && v && in_ready) acc_q.push_back(cyc);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      res_ready = rr;
      reset     = rst;
      if (rst) begin
         age = -1; e_opa = '0; e_opb = '0; e_data = '0; e_done = '0; e_chk = 1'b0;
      end else if (age < 0) begin
         if (v) begin
            age = 1; e_opa = a; e_opb = b;
         end
      end else if (age >= LAT + 3) begin
         if (rr) begin
            age = -1; e_done = e_done + 16'd1;
         end
      end else begin
         if (age == LAT + 2) begin
            prod = (2*W)'(e_opa) * (2*W)'(e_opb);
            e_data = corrupt ? (prod ^ 10'd1) : prod;
            if (corrupt) e_chk = 1'b1;
         end
         age++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic idle_steps(input int n, input logic rr);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, rr, 1'b0);
   endtask

   // Present a pair with in_valid held until it is taken (bounded).
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic rr);
      int  tries;
      logic taken;
      tries = 0;
      do begin
         taken = (age < 0);
         step(1'b1, a, b, rr, 1'b0);
         tries++;
      end while (!taken && tries < 40);
      if (!taken) check("issue_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [W-1:0] rand_op();
      logic [W-1:0] r;
      case ($urandom_range(0, 3))
         0: r = '0;
         1: r = '1;
         default: r = W'($urandom);
      endcase
      return r;
   endfunction

   logic [W-1:0] pa [4] = '{5'd7, 5'd31, 5'd2, 5'd19};
   logic [W-1:0] pb [4] = '{5'd6, 5'd1, 5'd2, 5'd23};

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      step(1'b0, '0, '0, 1'b0, 1'b1);          // reset state
      step(1'b1, 5'd9, 5'd9, 1'b1, 1'b1);      // reset beats in_valid
      // Single op, then max and zero operands.
      issue(5'd5, 5'd3, 1'b1);
      idle_steps(12, 1'b1);
      check("single_product", res_data, 32'd15);
      issue(5'd31, 5'd31, 1'b1);
      idle_steps(12, 1'b1);
      check("max_product", res_data, 32'd961);
      issue(5'd0, 5'd17, 1'b1);
      idle_steps(12, 1'b1);
      // Backpressure, with ignored in_valid traffic while busy.
      issue(5'd12, 5'd9, 1'b0);
      for (int i = 0; i < 9 + 20; i++) step(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
      check("bp_hold_data", res_data, 32'd108);
      step(1'b0, '0, '0, 1'b1, 1'b0);
      idle_steps(2, 1'b1);
      // Back-to-back with in_valid held high.
      acc_q.delete();
      for (int i = 0; i < 4; i++) issue(pa[i], pb[i], 1'b1);
      idle_steps(12, 1'b1);
      check("b2b_accepts", acc_q.size(), 32'd4);
      for (int i = 1; i < acc_q.size(); i++)
         check("b2b_spacing", acc_q[i] - acc_q[i-1], LAT + 4);
      // Reset four cycles after load.
      issue(5'd9, 5'd9, 1'b1);
      idle_steps(4, 1'b1);
      step(1'b1, 5'd3, 5'd3, 1'b1, 1'b1);
      idle_steps(1, 1'b1);
      issue(5'd10, 5'd10, 1'b1);
      idle_steps(12, 1'b1);
      check("after_reset_product", res_data, 32'd100);
`ifdef MUL_ISSUE_CHECK_EN
      corrupt = 1'b1;
      issue(5'd3, 5'd3, 1'b1);
      idle_steps(12, 1'b1);
      corrupt = 1'b0;
      check("chk_set", chk_err, 32'd1);
      issue(5'd2, 5'd2, 1'b1);
      idle_steps(12, 1'b1);
      check("chk_sticky", chk_err, 32'd1);
      step(1'b0, '0, '0, 1'b1, 1'b1);
      idle_steps(1, 1'b1);
`endif
      // Randomized traffic with occasional reset.
      for (int i = 0; i < 800; i++)
         step(1'($urandom_range(0, 1)), rand_op(), rand_op(),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 149) == 0));
      idle_steps(15, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
